// File: rtl/router_sync_n.sv
// router_sync_n: N-channel synchroniser between router FSM and output FIFOs.
// Steers writes to the latched destination and soft-resets FIFOs left unread too long.
module router_sync_n #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic              timeout_en,
  input  logic              clr_stats,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int SW = DROP_W + 5;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  logic [ADDR_W-1:0] sel_addr_q, sel_addr_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d, stall, sel_oh;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [SW-1:0]     drop_sum;
  assign addr_err  = {1'b0, sel_addr_q} >= (ADDR_W+1)'(NUM_CH);
  assign write_enb = (write_enb_reg && !addr_err) ? sel_oh : '0;
  // an invalid destination reports full so the FSM never writes into nowhere
  assign fifo_full = addr_err | (|(full & sel_oh));
  assign vld_out   = ~empty;
  assign sel_addr   = sel_addr_q;
  assign soft_reset = soft_reset_q;
  assign drop_cnt   = drop_cnt_q;
  always_comb begin
    sel_addr_d = detect_add ? data_in : sel_addr_q;
    drop_sum   = SW'(drop_cnt_q);
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i]       = sel_addr_q == ADDR_W'(i);
      stall[i]        = timeout_en & ~empty[i] & ~read_enb[i];
      soft_reset_d[i] = stall[i] && cnt_q[i] == CW'(TIMEOUT - 1);
      cnt_d[i]        = (stall[i] && !soft_reset_d[i]) ? cnt_q[i] + CW'(1) : '0;
      drop_sum        = drop_sum + SW'(soft_reset_d[i]);
    end
    drop_cnt_d = clr_stats ? '0 : (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_addr_q   <= '0;
      soft_reset_q <= '0;
      drop_cnt_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      sel_addr_q   <= sel_addr_d;
      soft_reset_q <= soft_reset_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised N-channel synchroniser between the router FSM and the output FIFOs.
- Latches the packet destination address and steers write_enb to the selected FIFO; returns that FIFO's full flag to the FSM.
- Drives vld_out from FIFO empty flags.
- Runs a per-channel read-timeout watchdog that soft-resets an unread FIFO.
- New over the fixed 4-channel version:
  - channel count, address width and timeout are parameters;
  - out-of-range addresses are detected;
  - the watchdog can be disabled at run time;
  - a saturating drop-event counter is provided;
  - counters clear when a channel goes empty.

Parameters:
- NUM_CH, 4: number of output channels/FIFOs, 2..16.
- ADDR_W, 2: destination address width; 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30: consecutive stalled cycles before soft reset, 2..1024. Internal counter width is clog2(TIMEOUT).
- DROP_W, 8: width of the drop-event counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- detect_add  in  1  FSM strobe: data_in carries the destination address this cycle.
- data_in  in  ADDR_W  destination address.
- write_enb_reg  in  1  FSM write request for the current packet byte.
- full  in  NUM_CH  per-FIFO full flags.
- empty  in  NUM_CH  per-FIFO empty flags.
- read_enb  in  NUM_CH  per-channel downstream read enables.
- timeout_en  in  1  watchdog enable.
- clr_stats  in  1  synchronous clear of drop_cnt.
- write_enb  out  NUM_CH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the selected FIFO.
- addr_err  out  1  latched address is >= NUM_CH.
- sel_addr  out  ADDR_W  latched destination address.
- vld_out  out  NUM_CH  per-channel data valid.
- soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse.
- drop_cnt  out  DROP_W  saturating count of soft-reset events.

Behaviour:
- **Reset** (resetn=0 at edge):
  - sel_addr=0, soft_reset=0, drop_cnt=0, all watchdog counters=0.
  - Combinational outputs follow the reset register values: addr_err=0, write_enb=0 unless write_enb_reg.
- **Address latch:**
  - detect_add=1 at edge t: sel_addr<=data_in, visible from t+1.
  - detect_add=0: sel_addr holds.
  - detect_add asserted again mid-packet: simply re-latches, no error.
- **addr_err:** combinational, sel_addr >= NUM_CH. Never asserts when NUM_CH == 2**ADDR_W.
- **write_enb:** combinational.
  - Bit sel_addr set iff write_enb_reg=1 and addr_err=0.
  - Otherwise all zero; at most one bit ever set.
- **fifo_full:** combinational.
  - full[sel_addr] when addr_err=0.
  - 1 when addr_err=1, so the FSM stalls or drops rather than writing nowhere.
- **vld_out[i]:** combinational, ~empty[i], no latency.
- **Watchdog, per channel i, evaluated at each edge:**
  - timeout_en=0, vld_out[i]=0 or read_enb[i]=1: cnt<=0, soft_reset[i]<=0.
  - Otherwise, if cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1, soft_reset[i]<=0.
- **Watchdog timing:**
  - soft_reset[i] goes high in the cycle after the TIMEOUT-th consecutive stalled cycle.
  - It is exactly one cycle wide.
  - If the channel is still stalled, the next pulse follows TIMEOUT cycles later.
- **Watchdog channel independence:** channels are independent, and the watchdog ignores write activity.
- **drop_cnt:**
  - At each edge, adds the number of soft_reset bits being set this edge (popcount of the next soft_reset value).
  - Saturates at 2**DROP_W-1, never wraps.
  - clr_stats=1 takes priority: drop_cnt<=0 and that edge's events are discarded.
- **Reset mid-operation:** pending counts are discarded; no soft_reset pulse is produced on the edge reset is applied.

Test Plan:
1. NUM_CH=4: detect_add with data_in=2, then write_enb_reg=1, full=4'b0100 -> from next cycle write_enb=4'b0100, fifo_full=1, addr_err=0. With write_enb_reg=0 -> write_enb=0.
2. NUM_CH=3, ADDR_W=2: latch data_in=3, write_enb_reg=1 -> write_enb=3'b000, fifo_full=1, addr_err=1. Latching 1 then gives write_enb=3'b010, addr_err=0.
3. TIMEOUT=30, timeout_en=1, empty[0]=0, read_enb[0]=0 for 70 cycles -> soft_reset[0] pulses in cycles 30 and 60 after stall start, one cycle each; drop_cnt=2.
4. Same stall, read_enb[0]=1 at stall cycle 29 -> no pulse, counter restarts. empty[0]=1 at cycle 20, then refilled -> full 30 further cycles needed before a pulse.
5. All 4 channels stalled simultaneously for 30 cycles -> soft_reset=4'b1111 for one cycle, drop_cnt +4. DROP_W=2 with a further event -> drop_cnt stays 3. clr_stats=1 on an event edge -> drop_cnt=0.
6. timeout_en=0 with a 100-cycle stall -> no soft_reset. resetn=0 at stall cycle 25, released -> no pulse until 30 new stall cycles; sel_addr=0 after reset.
